// File: rtl/hazard_scoreboard_unit.sv
// Hazard scoreboard for the RV32I pipeline.
// Each register has a countdown of remaining load-use stall cycles. The
// countdown covers load latencies longer than one cycle. Branch flush,
// memory-busy freeze and a saturating stall-cycle counter are also handled here.
// The write enables and bubble/flush controls are combinational, because they
// must react in the same cycle as the EX/ID contents they depend on.
module hazard_scoreboard_unit #(
    parameter int NREG     = 32,
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             IDEX_MemRead,
    input  logic [REG_W-1:0] IDEX_RegisterRd,
    input  logic [REG_W-1:0] IFID_RegisterR1,
    input  logic [REG_W-1:0] IFID_RegisterR2,
    input  logic             IFID_UsesR1,
    input  logic             IFID_UsesR2,
    input  logic             BranchTaken,
    input  logic             MemBusy,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             Bolha,
    output logic             FlushIFID,
    output logic [CNT_W-1:0] StallCount
);

    localparam int PEND_W = $clog2(LOAD_LAT + 1);
    // The load in EX already causes one stall through the direct compare.
    // The countdown therefore only covers the remaining LOAD_LAT-1 cycles.
    localparam logic [PEND_W-1:0] CAP_VAL  = PEND_W'(LOAD_LAT - 1);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};

    logic [PEND_W-1:0] pend_r [NREG];
    logic [CNT_W-1:0]  stall_count_r;
    logic              capture_s;
    logic              hazard1_s;
    logic              hazard2_s;
    logic              load_stall_s;
    logic              stall_case_s;

    // The register index is compared against every entry rather than used to
    // index pend_r directly. An index above NREG-1 then reads as not pending.
    // Entry 0 is skipped because x0 never carries a hazard.
    function automatic logic pend_busy(input logic [REG_W-1:0] idx);
        logic busy;
        busy = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            busy = busy | ((idx == REG_W'(r)) && (pend_r[r] != PEND_ZERO));
        end
        return busy;
    endfunction

    function automatic logic operand_hazard(input logic uses, input logic [REG_W-1:0] rs);
        return uses && (rs != {REG_W{1'b0}}) &&
               ((IDEX_MemRead && (IDEX_RegisterRd == rs)) || pend_busy(rs));
    endfunction

    // Hazard detection and the prioritised pipeline control outputs
    always_comb begin
        capture_s    = IDEX_MemRead && (IDEX_RegisterRd != {REG_W{1'b0}});
        hazard1_s    = operand_hazard(IFID_UsesR1, IFID_RegisterR1);
        hazard2_s    = operand_hazard(IFID_UsesR2, IFID_RegisterR2);
        load_stall_s = hazard1_s | hazard2_s;
        stall_case_s = 1'b0;
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        IDEXWrite    = 1'b1;
        Bolha        = 1'b0;
        FlushIFID    = 1'b0;
        if (!reset_n) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXWrite = 1'b0;
            Bolha     = 1'b1;
        end else if (MemBusy) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXWrite = 1'b0;
        end else if (BranchTaken) begin
            // The ID instruction is squashed, so any stall it would need is moot
            Bolha     = 1'b1;
            FlushIFID = 1'b1;
        end else if (load_stall_s) begin
            PCWrite      = 1'b0;
            IFIDWrite    = 1'b0;
            Bolha        = 1'b1;
            stall_case_s = 1'b1;
        end else begin
            stall_case_s = 1'b0;
        end
    end

    // Per-register countdown: a new load captures, other entries decay, MemBusy freezes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                pend_r[r] <= PEND_ZERO;
            end
        end else if (!MemBusy) begin
            for (int r = 0; r < NREG; r++) begin
                if (r == 0) begin
                    pend_r[r] <= PEND_ZERO;
                end else if (capture_s && (IDEX_RegisterRd == REG_W'(r))) begin
                    pend_r[r] <= CAP_VAL;
                end else if (pend_r[r] != PEND_ZERO) begin
                    pend_r[r] <= pend_r[r] - PEND_ONE;
                end else begin
                    pend_r[r] <= pend_r[r];
                end
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                pend_r[r] <= pend_r[r];
            end
        end
    end

    // Saturating count of cycles spent in a load-use stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (stall_case_s && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign StallCount = stall_count_r;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: three instances (LOAD_LAT 1, 2, 3) share
// one stimulus stream and are checked every cycle against a load-timestamp
// model, plus hand-computed spot checks per scenario.
module tb_hazard_scoreboard_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       mem_read;
    logic [4:0] rd, r1, r2;
    logic       u1, u2, br, mb;

    logic        pcw [3];
    logic        ifw [3];
    logic        idw [3];
    logic        bol [3];
    logic        fl  [3];
    logic [15:0] cnt0, cnt2;
    logic [2:0]  cnt1;

    logic [4:0]  ctl_a [3];
    logic [15:0] cnt_a [3];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // model: register -> index of the non-frozen cycle whose EX held its latest load
    int last_load [32];
    int tick_q = 0;
    int model_cnt [3];
    int cmax [3] = '{65535, 7, 65535};

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.NREG(32), .REG_W(5), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
        .clk(clk), .reset_n(reset_n), .IDEX_MemRead(mem_read), .IDEX_RegisterRd(rd),
        .IFID_RegisterR1(r1), .IFID_RegisterR2(r2), .IFID_UsesR1(u1), .IFID_UsesR2(u2),
        .BranchTaken(br), .MemBusy(mb), .PCWrite(pcw[0]), .IFIDWrite(ifw[0]),
        .IDEXWrite(idw[0]), .Bolha(bol[0]), .FlushIFID(fl[0]), .StallCount(cnt0));

    hazard_scoreboard_unit #(.NREG(32), .REG_W(5), .LOAD_LAT(2), .CNT_W(3)) u_lat2 (
        .clk(clk), .reset_n(reset_n), .IDEX_MemRead(mem_read), .IDEX_RegisterRd(rd),
        .IFID_RegisterR1(r1), .IFID_RegisterR2(r2), .IFID_UsesR1(u1), .IFID_UsesR2(u2),
        .BranchTaken(br), .MemBusy(mb), .PCWrite(pcw[1]), .IFIDWrite(ifw[1]),
        .IDEXWrite(idw[1]), .Bolha(bol[1]), .FlushIFID(fl[1]), .StallCount(cnt1));

    hazard_scoreboard_unit #(.NREG(32), .REG_W(5), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
        .clk(clk), .reset_n(reset_n), .IDEX_MemRead(mem_read), .IDEX_RegisterRd(rd),
        .IFID_RegisterR1(r1), .IFID_RegisterR2(r2), .IFID_UsesR1(u1), .IFID_UsesR2(u2),
        .BranchTaken(br), .MemBusy(mb), .PCWrite(pcw[2]), .IFIDWrite(ifw[2]),
        .IDEXWrite(idw[2]), .Bolha(bol[2]), .FlushIFID(fl[2]), .StallCount(cnt2));

    assign ctl_a[0] = {pcw[0], ifw[0], idw[0], bol[0], fl[0]};
    assign ctl_a[1] = {pcw[1], ifw[1], idw[1], bol[1], fl[1]};
    assign ctl_a[2] = {pcw[2], ifw[2], idw[2], bol[2], fl[2]};
    assign cnt_a[0] = cnt0;
    assign cnt_a[1] = {13'd0, cnt1};
    assign cnt_a[2] = cnt2;

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // reader of rs must still wait if its latest load was in EX fewer than lat cycles ago
    function automatic logic model_haz(input int lat, input logic use_op, input logic [4:0] rs);
        if (!use_op || rs == 5'd0) return 1'b0;
        if (mem_read && rd == rs) return 1'b1;
        return (tick_q - last_load[rs]) < lat;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) last_load[r] = -1000;
        for (int i = 0; i < 3; i++) model_cnt[i] = 0;
    endtask

    // per-cycle comparison against the model, then advance the model over the next edge
    always @(negedge clk) begin
        logic [4:0] exp_ctl;
        logic       stall [3];
        cyc = cyc + 1;
        if (!reset_n) model_clear();
        for (int i = 0; i < 3; i++) begin
            stall[i] = model_haz(i + 1, u1, r1) | model_haz(i + 1, u2, r2);
            if (!reset_n)       exp_ctl = 5'b00010;
            else if (mb)        exp_ctl = 5'b00000;
            else if (br)        exp_ctl = 5'b11111;
            else if (stall[i])  exp_ctl = 5'b00110;
            else                exp_ctl = 5'b11100;
            check($sformatf("model_ctl_lat%0d", i + 1), int'(ctl_a[i]), int'(exp_ctl));
            check($sformatf("model_cnt_lat%0d", i + 1), int'(cnt_a[i]), model_cnt[i]);
        end
        if (reset_n && !mb) begin
            for (int i = 0; i < 3; i++) begin
                if (!br && stall[i] && model_cnt[i] < cmax[i]) model_cnt[i] = model_cnt[i] + 1;
            end
            if (mem_read && rd != 5'd0) last_load[rd] = tick_q;
            tick_q = tick_q + 1;
        end
    end

    task automatic drive(input logic m, input logic [4:0] d, input logic [4:0] a,
                         input logic [4:0] b, input logic ua, input logic ub,
                         input logic bt, input logic bz);
        mem_read = m; rd = d; r1 = a; r2 = b; u1 = ua; u2 = ub; br = bt; mb = bz;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        model_clear();
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_bolha", int'(bol[0]), 1);
        check("rst_pcw", int'(pcw[0]), 0);
        check("rst_idw", int'(idw[2]), 0);
        check("rst_cnt", int'(cnt2), 0);
        tick();
        tick();
        reset_n = 1'b1;

        // 1: no load in EX
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 5'd3, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
            check("t1_pcw", int'(pcw[0]), 1);
            check("t1_bolha", int'(bol[0]), 0);
            tick();
        end
        check("t1_cnt", int'(cnt0), 0);

        // 2: single-bubble load-use on rs2
        do_reset();
        drive(1'b1, 5'd3, 5'd5, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_pcw", int'(pcw[0]), 0);
        check("t2_bolha", int'(bol[0]), 1);
        check("t2_idw", int'(idw[0]), 1);
        tick();
        drive(1'b0, 5'd0, 5'd5, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t2_release", int'(pcw[0]), 1);
        check("t2_cnt", int'(cnt0), 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end

        // 3: LOAD_LAT=3 dependent held in ID
        do_reset();
        drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_c0_pcw", int'(pcw[2]), 0);
        tick();
        for (int k = 1; k < 3; k++) begin
            drive(1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            check("t3_hold_pcw", int'(pcw[2]), 0);
            tick();
        end
        drive(1'b0, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_release", int'(pcw[2]), 1);
        check("t3_cnt_lat3", int'(cnt2), 3);
        check("t3_cnt_lat2", int'(cnt1), 2);
        check("t3_cnt_lat1", int'(cnt0), 1);
        tick();
        // 3b: same but rs1 not used
        do_reset();
        drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3b_pcw", int'(pcw[2]), 1);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        check("t3b_cnt", int'(cnt2), 0);

        // 4: load to x0
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t4_pcw", int'(pcw[2]), 1);
        tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("t4_cnt", int'(cnt2), 0);

        // 4b: reader two slots behind the load (independent filler between)
        do_reset();
        drive(1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 5'd1, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        check("t4b_cnt_lat3", int'(cnt2), 2);
        check("t4b_cnt_lat2", int'(cnt1), 1);
        check("t4b_cnt_lat1", int'(cnt0), 0);

        // 5: branch taken in the second stall cycle
        do_reset();
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t5_flush", int'(fl[2]), 1);
        check("t5_bolha", int'(bol[2]), 1);
        check("t5_pcw", int'(pcw[2]), 1);
        tick();
        drive(1'b0, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_restall", int'(pcw[2]), 0);
        tick();
        drive(1'b0, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_release", int'(pcw[2]), 1);
        check("t5_cnt", int'(cnt2), 2);
        tick();

        // 6: MemBusy freeze during a LOAD_LAT=2 stall
        do_reset();
        drive(1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_c0_pcw", int'(pcw[1]), 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
            check("t6_busy_ctl", int'(ctl_a[1]), 0);
            tick();
            check("t6_busy_cnt", int'(cnt1), 1);
        end
        drive(1'b0, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_resume", int'(pcw[1]), 0);
        tick();
        drive(1'b0, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_release", int'(pcw[1]), 1);
        check("t6_cnt", int'(cnt1), 2);
        tick();

        // 6b: saturation of the 3-bit counter, then reset in mid-stall
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6b_sat", int'(cnt1), 7);
        check("t6b_cnt_lat1", int'(cnt0), 10);
        reset_n = 1'b0;
        #1;
        check("t6b_rst_cnt", int'(cnt1), 0);
        check("t6b_rst_cnt3", int'(cnt2), 0);
        check("t6b_rst_bolha", int'(bol[0]), 1);
        check("t6b_rst_pcw", int'(pcw[0]), 0);
        tick();
        reset_n = 1'b1;
        drive(1'b0, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6b_post_rst", int'(pcw[2]), 1);
        tick();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
